bambu_slave_mem_driver: RTL and testbench

- Drives an HLS-generated `main` core through its slave memory port (channel 0) for the integer benchmark flow.
- Loads an input byte image into the core's internal array, pulses start_port, waits for done_port and counts execution cycles.
- Reads the array back and streams it out as 32-bit words.
- Sits directly upstream of the `main` core, replacing the file-driven preload and done/cycle logic with synthesizable RTL.

---
 rtl/bambu_slave_mem_driver.sv | 188 ++++++++++++++++++
 tb/tb_bambu_slave_mem_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bambu_slave_mem_driver.sv
// Loads a byte image into an HLS `main` core via slave channel 0, runs it, and streams the array back.
// Optional build macro SLAVE_DRV_SORT_CHECK_EN adds a signed ascending-order check on readback.
module bambu_slave_mem_driver #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 64,
  parameter int SIZE_W    = 7,
  parameter int NUM_WORDS = 100,
  parameter int BASE_ADDR = 128,
  parameter int TIMEOUT   = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic                  busy,
  output logic                  finished,
  output logic                  timeout,
  output logic [31:0]           cycle_count,
  output logic                  sort_err
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] LOAD   = 4'd1;
  localparam logic [3:0] WRITE  = 4'd2;
  localparam logic [3:0] START  = 4'd3;
  localparam logic [3:0] RUN    = 4'd4;
  localparam logic [3:0] RDREQ  = 4'd5;
  localparam logic [3:0] RDWAIT = 4'd6;
  localparam logic [3:0] EMIT   = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [3:0]        state;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       word_buf;
  logic [31:0]       rd_buf;
  logic [31:0]       cycle_reg;
  logic              timeout_reg;

  logic              last_word;
  logic              access;
  logic [ADDR_W-1:0] acc_addr;

  assign last_word = (word_idx == LAST_IDX);
  assign access    = (state == WRITE) || (state == RDREQ);
  // Address wraps modulo 2^ADDR_W by construction of the sized sum.
  assign acc_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      word_idx    <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      rd_buf      <= '0;
      cycle_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= LOAD;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          if (last_word) begin
            state <= START;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            state    <= LOAD;
          end
        end
        START: begin
          cycle_reg <= 32'd1;
          state     <= RUN;
        end
        RUN: begin
          if (done_port) begin
            word_idx <= '0;
            state    <= RDREQ;
          end else if (cycle_reg >= 32'(TIMEOUT)) begin
            timeout_reg <= 1'b1;
            state       <= DONE;
          end else begin
            cycle_reg <= cycle_reg + 32'd1;
          end
        end
        RDREQ: state <= RDWAIT;
        RDWAIT: begin
          if (Sout_DataRdy[0]) begin
            rd_buf <= Sout_Rdata_ram[31:0];
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_word) begin
              state <= DONE;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
              state    <= RDREQ;
            end
          end
        end
        DONE: begin
          if (go) begin
            state       <= LOAD;
            word_idx    <= '0;
            byte_idx    <= '0;
            timeout_reg <= 1'b0;
            cycle_reg   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SLAVE_DRV_SORT_CHECK_EN
  logic [31:0] prev_word;
  logic        sort_err_reg;

  // prev_word tracks the last word handed off downstream; word 0 is never compared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_word    <= '0;
      sort_err_reg <= 1'b0;
    end else if (state == DONE && go) begin
      sort_err_reg <= 1'b0;
    end else if (state == EMIT) begin
      if (word_idx != '0 && $signed(rd_buf) < $signed(prev_word)) sort_err_reg <= 1'b1;
      if (out_ready) prev_word <= rd_buf;
    end
  end

  assign sort_err = sort_err_reg;
`else
  assign sort_err = 1'b0;
`endif

  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == EMIT);
  assign out_data    = rd_buf;
  assign out_last    = (state == EMIT) && last_word;
  assign start_port  = (state == START);
  assign busy        = (state != IDLE) && (state != DONE);
  assign finished    = (state == DONE);
  assign timeout     = timeout_reg;
  assign cycle_count = cycle_reg;

  assign S_we_ram        = {1'b0, state == WRITE};
  assign S_oe_ram        = {1'b0, state == RDREQ};
  assign S_addr_ram      = {ADDR_W'(0), access ? acc_addr : ADDR_W'(0)};
  assign S_Wdata_ram     = {DATA_W'(0), (state == WRITE) ? DATA_W'(word_buf) : DATA_W'(0)};
  assign S_data_ram_size = {SIZE_W'(0), access ? SIZE_W'(32) : SIZE_W'(0)};

  // Channel 1 and the upper read-data bits are never consumed.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, Sout_Rdata_ram[2*DATA_W-1:32], Sout_DataRdy[1]};

endmodule

// File: tb/tb_bambu_slave_mem_driver.sv
// Directed bench for bambu_slave_mem_driver with a small slave-memory model and a core done model.
module tb_bambu_slave_mem_driver;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;

`ifdef SLAVE_DRV_SORT_CHECK_EN
  localparam logic EXP_SORT = 1'b1;
`else
  localparam logic EXP_SORT = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                go = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          in_data = 8'h00;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [31:0]         out_data;
  logic                out_last;
  logic [1:0]          S_oe_ram;
  logic [1:0]          S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [2*DATA_W-1:0] S_Wdata_ram;
  logic [2*SIZE_W-1:0] S_data_ram_size;
  logic [2*DATA_W-1:0] Sout_Rdata_ram;
  logic [1:0]          Sout_DataRdy;
  logic                start_port;
  logic                done_port = 1'b0;
  logic                busy;
  logic                finished;
  logic                timeout;
  logic [31:0]         cycle_count;
  logic                sort_err;

  bambu_slave_mem_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .NUM_WORDS(3), .BASE_ADDR(128), .TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset), .go(go),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port),
    .busy(busy), .finished(finished), .timeout(timeout),
    .cycle_count(cycle_count), .sort_err(sort_err)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave memory: writes land immediately, reads answer 2 cycles after the oe cycle.
  logic [31:0] mem [0:127];
  logic [31:0] rdata = 32'h0;
  logic        rdy = 1'b0;
  logic [6:0]  rd_index = 7'd0;
  int          rd_cnt = 0;
  int          oe_count = 0;
  logic        bad_bus = 1'b0;
  logic [8:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [6:0]  wr_size_q [$];

  assign Sout_Rdata_ram = {96'h0, rdata};
  assign Sout_DataRdy   = {1'b0, rdy};

  always @(posedge clock) begin
    rdy <= 1'b0;
    if (S_we_ram[1] || S_oe_ram[1] || (S_we_ram[0] && S_oe_ram[0]) ||
        S_addr_ram[17:9] != 9'h0 || S_data_ram_size[13:7] != 7'h0 || S_Wdata_ram[127:32] != 96'h0)
      bad_bus <= 1'b1;
    if (S_we_ram[0]) begin
      mem[S_addr_ram[8:2]] <= S_Wdata_ram[31:0];
      wr_addr_q.push_back(S_addr_ram[8:0]);
      wr_data_q.push_back(S_Wdata_ram[31:0]);
      wr_size_q.push_back(S_data_ram_size[6:0]);
    end
    if (S_oe_ram[0]) begin
      oe_count <= oe_count + 1;
      rd_index <= S_addr_ram[8:2];
      rd_cnt   <= 2;
    end else if (rd_cnt == 1) begin
      rdy    <= 1'b1;
      rdata  <= mem[rd_index];
      rd_cnt <= 0;
    end else if (rd_cnt > 1) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  // Core model: sees start_port on a clock edge, raises done_port 10 edges later.
  logic core_hang = 1'b0;
  int   core_cnt = 0;
  always @(posedge clock) begin
    if (start_port) begin
      done_port <= 1'b0;
      core_cnt  <= core_hang ? 0 : 10;
    end else if (core_cnt == 1) begin
      done_port <= 1'b1;
      core_cnt  <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic go_pulse();
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("in_ready_wait", {31'h0, in_ready}, 32'h1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  // Waits for the first RDREQ of a run; returns the number of negedges from START.
  task automatic wait_oe(output int n);
    n = 0;
    while (!S_oe_ram[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic read_back(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input bit stall);
    logic [31:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    for (int w = 0; w < 3; w++) begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("out_valid", {31'h0, out_valid}, 32'h1);
      if (stall && w == 1) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clock);
          check("stall_valid", {31'h0, out_valid}, 32'h1);
          check("stall_data", out_data, exp[w]);
        end
      end
      check("out_data", out_data, exp[w]);
      check("out_last", {31'h0, out_last}, (w == 2) ? 32'h1 : 32'h0);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_start", {31'h0, start_port}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_finished", {31'h0, finished}, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    check("rst_cycles", cycle_count, 32'h0);
    check("rst_sort_err", {31'h0, sort_err}, 32'h0);
    check("rst_en", {28'h0, S_we_ram, S_oe_ram}, 32'h0);
    check("rst_addr", {14'h0, S_addr_ram}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Load 3,1,2; core finishes 10 cycles after start; readback with a stall on word 1.
    go_pulse();
    check("load_in_ready", {31'h0, in_ready}, 32'h1);
    send_word(32'd3);
    send_word(32'd1);
    send_word(32'd2);
    @(negedge clock);
    check("start_pulse", {31'h0, start_port}, 32'h1);
    check("wr_count", wr_addr_q.size(), 32'd3);
    check("wr0_addr", {23'h0, wr_addr_q[0]}, 32'd128);
    check("wr1_addr", {23'h0, wr_addr_q[1]}, 32'd132);
    check("wr2_addr", {23'h0, wr_addr_q[2]}, 32'd136);
    check("wr0_data", wr_data_q[0], 32'd3);
    check("wr1_data", wr_data_q[1], 32'd1);
    check("wr2_data", wr_data_q[2], 32'd2);
    check("wr_size", {25'h0, wr_size_q[2]}, 32'd32);
    wait_oe(n);
    check("start_to_rdreq", n, 32'd12);
    check("run_cycles", cycle_count, 32'd11);
    check("rd_addr0", {14'h0, S_addr_ram}, 32'd128);
    check("rd_size", {18'h0, S_data_ram_size}, 32'd32);
    read_back(32'd3, 32'd1, 32'd2, 1'b1);
    check("finished", {31'h0, finished}, 32'h1);
    check("done_busy", {31'h0, busy}, 32'h0);
    check("done_timeout", {31'h0, timeout}, 32'h0);

    // Reset in the middle of a word aborts everything.
    go_pulse();
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_finished", {31'h0, finished}, 32'h0);
    check("mid_rst_cycles", cycle_count, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_size_q.delete();
    @(negedge clock);

    // Fresh load of 1,5,-2; done_port is still high from the last run and must be ignored at START.
    go_pulse();
    send_word(32'd1);
    @(negedge clock);
    check("fresh_wr_count", wr_addr_q.size(), 32'd1);
    check("fresh_wr_addr", {23'h0, wr_addr_q[0]}, 32'd128);
    check("fresh_wr_data", wr_data_q[0], 32'd1);
    send_word(32'd5);
    send_word(32'hFFFF_FFFE);
    wait_oe(n);
    check("run2_cycles", cycle_count, 32'd11);
    read_back(32'd1, 32'd5, 32'hFFFF_FFFE, 1'b0);
    check("sort_err_unsorted", {31'h0, sort_err}, {31'h0, EXP_SORT});

    // go from DONE clears sort_err; sorted data -2,1,5 keeps it clear.
    go_pulse();
    check("go_clears_sort", {31'h0, sort_err}, 32'h0);
    check("go_clears_cycles", cycle_count, 32'h0);
    send_word(32'hFFFF_FFFE);
    send_word(32'd1);
    send_word(32'd5);
    wait_oe(n);
    read_back(32'hFFFF_FFFE, 32'd1, 32'd5, 1'b0);
    check("sort_err_sorted", {31'h0, sort_err}, 32'h0);

    // Core never finishes: timeout at 50 cycles with no readback.
    core_hang = 1'b1;
    go_pulse();
    send_word(32'd7);
    send_word(32'd8);
    send_word(32'd9);
    n = oe_count;
    begin
      int k = 0;
      while (!finished && k < 300) begin
        @(negedge clock);
        k++;
      end
    end
    check("to_finished", {31'h0, finished}, 32'h1);
    check("to_flag", {31'h0, timeout}, 32'h1);
    check("to_cycles", cycle_count, 32'd50);
    check("to_no_oe", oe_count, n);
    check("to_no_valid", {31'h0, out_valid}, 32'h0);
    go_pulse();
    check("go_clears_timeout", {31'h0, timeout}, 32'h0);
    check("bus_upper_clean", {31'h0, bad_bus}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
